dsram_responder: RTL and testbench

Slave end of the CPU's SRAM-lite data port, the counterpart to the core's `dce`/`we`/`daddr`/`din`/`dm` initiator. It decodes each data access into either a byte-writable on-chip data RAM or a small memory-mapped peripheral block. The peripheral block contains the LED register, a synchronized switch input, and a free-running timer with a compare interrupt. Read data comes back one clock after the request, aligned with the core's WB-stage capture of `dm`.

---
 rtl/dsram_responder_pkg.sv | 46 ++++
 rtl/dsram_responder_if.sv | 11 +
 rtl/dsram_responder_bram_be.sv | 29 ++
 rtl/dsram_responder.sv | 103 ++++++++++
 tb/tb_dsram_responder.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/dsram_responder_pkg.sv
// Shared constants and helpers for the SRAM-lite data-port responder.
package dsram_responder_pkg;

  localparam logic [15:0] MMIO_HI_DEF = 16'hBFAF;

  localparam logic [15:0] LED_OFS     = 16'h0000;
  localparam logic [15:0] TIMER_OFS   = 16'h0004;
  localparam logic [15:0] SWITCH_OFS  = 16'h0008;
  localparam logic [15:0] COMPARE_OFS = 16'h000C;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    REG_LED,
    REG_TIMER,
    REG_SWITCH,
    REG_COMPARE,
    REG_NONE
  } mmio_reg_e;

  // Replace the byte lanes of old_v selected by be with the lanes of new_v.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // Word-granular offset decode; the two byte-offset bits are ignored.
  function automatic mmio_reg_e decode_ofs(input logic [15:0] ofs);
    mmio_reg_e r;
    case ({ofs[15:2], 2'b00})
      LED_OFS:     r = REG_LED;
      TIMER_OFS:   r = REG_TIMER;
      SWITCH_OFS:  r = REG_SWITCH;
      COMPARE_OFS: r = REG_COMPARE;
      default:     r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dsram_responder_if.sv
// CPU data-port bus: request from the core, registered read data back.
interface dsram_responder_if;
  logic        dce;
  logic [3:0]  we;
  logic [31:0] daddr;
  logic [31:0] din;
  logic [31:0] dm;

  modport master (output dce, we, daddr, din, input dm);
  modport slave  (input dce, we, daddr, din, output dm);
endinterface

// File: rtl/dsram_responder_bram_be.sv
// Single-port data RAM with four byte-write lanes and a synchronous read port.
// The read register only loads on read cycles, so it holds across writes/idles.
module bram_be #(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   din_i,
  output logic [31:0]   dout_o
);

  logic [31:0] mem_q [0:(1<<AW)-1];
  logic [31:0] dout_q;

  // Byte-lane write, or registered read when no lane is enabled.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (we_i[i]) mem_q[addr_i][8*i +: 8] <= din_i[8*i +: 8];
      end
      if (we_i == 4'b0000) dout_q <= mem_q[addr_i];
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/dsram_responder.sv
// Data-port responder: decodes core accesses into byte-writable RAM or the
// LED / timer / switch / compare register block; read data one cycle later.
module dsram_responder
  import dsram_responder_pkg::*;
#(
  parameter int          RAM_AW  = 10,
  parameter logic [15:0] MMIO_HI = MMIO_HI_DEF
) (
  input  logic                cpu_clk_50M,
  input  logic                cpu_rst,
  dsram_responder_if.slave    bus,
  input  logic [15:0]         switch,
  output logic [15:0]         led,
  output logic                timer_int
);

  logic        is_mmio, acc_rd, acc_wr, ram_en;
  logic        led_wr, timer_wr, cmp_wr;
  mmio_reg_e   reg_sel;
  logic [31:0] ram_dout, led_word;

  logic [15:0] led_q, led_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] compare_q, compare_d;
  logic        int_q, int_d;
  logic [15:0] sync1_q, sync2_q;
  logic [31:0] mmio_rdata_q, mmio_rdata_d;
  logic        sel_mmio_q, sel_mmio_d;

  assign is_mmio = (bus.daddr[31:16] == MMIO_HI);
  assign acc_rd  = bus.dce && (bus.we == 4'b0000);
  assign acc_wr  = bus.dce && (bus.we != 4'b0000);
  assign reg_sel = decode_ofs(bus.daddr[15:0]);
  // RAM has no reset of its own, so a write that overlaps reset is blocked here.
  assign ram_en  = bus.dce && !is_mmio && !cpu_rst;

  bram_be #(.AW(RAM_AW)) u_ram (
    .clk_i  (cpu_clk_50M),
    .en_i   (ram_en),
    .we_i   (bus.we),
    .addr_i (bus.daddr[RAM_AW+1:2]),
    .din_i  (bus.din),
    .dout_o (ram_dout)
  );

  // Register write strobes for the peripheral block.
  always_comb begin
    led_wr   = acc_wr && is_mmio && (reg_sel == REG_LED);
    timer_wr = acc_wr && is_mmio && (reg_sel == REG_TIMER);
    cmp_wr   = acc_wr && is_mmio && (reg_sel == REG_COMPARE);
  end

  // Next-state of the peripheral registers and the read-path selection.
  always_comb begin
    led_word  = merge_lanes({16'h0000, led_q}, bus.din, {2'b00, bus.we[1:0]});
    led_d     = led_wr ? led_word[15:0] : led_q;
    // A TIMER write takes the place of that cycle's increment.
    timer_d   = timer_wr ? merge_lanes(timer_q, bus.din, bus.we) : timer_q + 32'd1;
    compare_d = cmp_wr ? merge_lanes(compare_q, bus.din, bus.we) : compare_q;
    // Match uses pre-increment values; a COMPARE write always clears.
    int_d     = cmp_wr ? 1'b0 : ((timer_q == compare_q) ? 1'b1 : int_q);

    mmio_rdata_d = mmio_rdata_q;
    if (acc_rd && is_mmio) begin
      case (reg_sel)
        REG_LED:     mmio_rdata_d = {16'h0000, led_q};
        REG_TIMER:   mmio_rdata_d = timer_q;
        REG_SWITCH:  mmio_rdata_d = {16'h0000, sync2_q};
        REG_COMPARE: mmio_rdata_d = compare_q;
        default:     mmio_rdata_d = 32'h0000_0000;
      endcase
    end
    sel_mmio_d = acc_rd ? is_mmio : sel_mmio_q;
  end

  // State registers; sel_mmio resets to the MMIO side so dm reads the zeroed register.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      led_q        <= 16'h0000;
      timer_q      <= 32'h0000_0000;
      compare_q    <= COMPARE_RST;
      int_q        <= 1'b0;
      sync1_q      <= 16'h0000;
      sync2_q      <= 16'h0000;
      mmio_rdata_q <= 32'h0000_0000;
      sel_mmio_q   <= 1'b1;
    end else begin
      led_q        <= led_d;
      timer_q      <= timer_d;
      compare_q    <= compare_d;
      int_q        <= int_d;
      sync1_q      <= switch;
      sync2_q      <= sync1_q;
      mmio_rdata_q <= mmio_rdata_d;
      sel_mmio_q   <= sel_mmio_d;
    end
  end

  assign bus.dm    = sel_mmio_q ? mmio_rdata_q : ram_dout;
  assign led       = led_q;
  assign timer_int = int_q;

endmodule

// File: tb/tb_dsram_responder.sv
// Directed bench for dsram_responder with a cycle-level reference model.
module tb_dsram_responder;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst     = 1'b1;
  logic [15:0] switch      = 16'h0000;
  logic [15:0] led;
  logic        timer_int;

  dsram_responder_if bus();

  dsram_responder dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst     (cpu_rst),
    .bus         (bus.slave),
    .switch      (switch),
    .led         (led),
    .timer_int   (timer_int)
  );

  always #5 cpu_clk_50M = ~cpu_clk_50M;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem   [0:1023];
  bit          m_known [0:1023];
  logic [31:0] m_dm, m_timer, m_cmp;
  logic [15:0] m_led, m_s1, m_s2;
  logic        m_int;
  bit          m_dm_known;
  bit          m_mmio, m_tw, m_cw, m_lw, m_match;
  logic [15:0] m_ofs;
  int          m_idx;

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  initial for (int i = 0; i < 1024; i++) m_known[i] = 0;

  always @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      m_dm = 0; m_dm_known = 1; m_led = 0; m_timer = 0; m_cmp = 32'hFFFF_FFFF;
      m_int = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      m_mmio  = (bus.daddr[31:16] == 16'hBFAF);
      m_ofs   = bus.daddr[15:0] & 16'hFFFC;
      m_idx   = int'(bus.daddr[11:2]);
      m_tw    = bus.dce && m_mmio && bus.we != 0 && m_ofs == 16'h4;
      m_cw    = bus.dce && m_mmio && bus.we != 0 && m_ofs == 16'hC;
      m_lw    = bus.dce && m_mmio && bus.we != 0 && m_ofs == 16'h0;
      m_match = (m_timer == m_cmp);
      if (bus.dce && bus.we == 0) begin
        m_dm_known = 1;
        if (!m_mmio) begin
          m_dm = m_mem[m_idx];
          m_dm_known = m_known[m_idx];
        end else if (m_ofs == 16'h0) m_dm = {16'h0, m_led};
        else if (m_ofs == 16'h4) m_dm = m_timer;
        else if (m_ofs == 16'h8) m_dm = {16'h0, m_s2};
        else if (m_ofs == 16'hC) m_dm = m_cmp;
        else m_dm = 0;
      end
      if (bus.dce && bus.we != 0 && !m_mmio) begin
        m_mem[m_idx] = lanes(m_mem[m_idx], bus.din, bus.we);
        if (bus.we == 4'hF) m_known[m_idx] = 1;
      end
      if (m_cw) m_int = 0;
      else if (m_match) m_int = 1;
      m_timer = m_tw ? lanes(m_timer, bus.din, bus.we) : m_timer + 1;
      if (m_cw) m_cmp = lanes(m_cmp, bus.din, bus.we);
      if (m_lw) m_led = m_led & ~{{8{bus.we[1]}}, {8{bus.we[0]}}}
                      | bus.din[15:0] & {{8{bus.we[1]}}, {8{bus.we[0]}}};
      m_s2 = m_s1;
      m_s1 = switch;
    end
  end

  bit chk_en = 0;
  always @(negedge cpu_clk_50M) begin
    if (chk_en && !cpu_rst) begin
      if (m_dm_known) chk("model_dm", bus.dm, m_dm);
      chk("model_led", {16'h0, led}, {16'h0, m_led});
      chk("model_int", {31'h0, timer_int}, {31'h0, m_int});
    end
  end

  // ---------------- stimulus ----------------
  task automatic acc(input logic dce, input logic [3:0] we,
                     input logic [31:0] addr, input logic [31:0] din);
    bus.dce = dce; bus.we = we; bus.daddr = addr; bus.din = din;
    @(posedge cpu_clk_50M); #1;
  endtask

  task automatic idle();
    acc(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    bus.dce = 0; bus.we = 0; bus.daddr = 0; bus.din = 0;
    repeat (2) @(posedge cpu_clk_50M);
    #1;
    chk("reset_dm", bus.dm, 32'h0);
    chk("reset_led", {16'h0, led}, 32'h0);
    chk("reset_int", {31'h0, timer_int}, 32'h0);
    cpu_rst = 0;
    chk_en  = 1;

    // byte-lane write
    acc(1, 4'hF, 32'h0000_0010, 32'h1122_3344);
    acc(1, 4'b0010, 32'h0000_0010, 32'h0000_AA00);
    acc(1, 4'h0, 32'h0000_0010, 32'h0);
    chk("byte_lane", bus.dm, 32'h1122_AA44);

    // back-to-back reads, hold on idle and write
    acc(1, 4'hF, 32'h0000_0014, 32'h5566_7788);
    acc(1, 4'h0, 32'h0000_0010, 32'h0);
    chk("b2b_first", bus.dm, 32'h1122_AA44);
    acc(1, 4'h0, 32'h0000_0014, 32'h0);
    chk("b2b_second", bus.dm, 32'h5566_7788);
    idle();
    chk("idle_hold", bus.dm, 32'h5566_7788);
    acc(1, 4'hF, 32'h0000_0018, 32'h0BAD_BEEF);
    chk("write_hold", bus.dm, 32'h5566_7788);

    // LED and switch
    acc(1, 4'hF, 32'hBFAF_0000, 32'hFFFF_1234);
    chk("led_out", {16'h0, led}, 32'h0000_1234);
    acc(1, 4'h0, 32'hBFAF_0000, 32'h0);
    chk("led_read", bus.dm, 32'h0000_1234);
    switch = 16'hA5A5;
    idle();
    idle();
    acc(1, 4'h0, 32'hBFAF_0008, 32'h0);
    chk("switch_read", bus.dm, 32'h0000_A5A5);

    // timer / compare
    acc(1, 4'hF, 32'hBFAF_000C, 32'd20);
    acc(1, 4'hF, 32'hBFAF_0004, 32'd10);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      idle();
      if (timer_int && k == 0) k = i;
    end
    chk("int_rise_cycle", k, 11);
    acc(1, 4'hF, 32'hBFAF_000C, 32'd100);
    chk("int_cleared", {31'h0, timer_int}, 32'h0);
    acc(1, 4'hF, 32'hBFAF_000C, 32'd60);
    acc(1, 4'hF, 32'hBFAF_0004, 32'd50);
    repeat (10) idle();
    acc(1, 4'hF, 32'hBFAF_000C, 32'd200);
    chk("int_write_wins", {31'h0, timer_int}, 32'h0);
    repeat (3) idle();

    // timer wrap
    acc(1, 4'hF, 32'hBFAF_0004, 32'hFFFF_FFFE);
    idle();
    acc(1, 4'h0, 32'hBFAF_0004, 32'h0);
    chk("timer_max", bus.dm, 32'hFFFF_FFFF);
    acc(1, 4'h0, 32'hBFAF_0004, 32'h0);
    chk("timer_wrap", bus.dm, 32'h0);

    // reset in the middle of a write
    acc(1, 4'hF, 32'h0000_0020, 32'hCAFE_F00D);
    bus.dce = 1; bus.we = 4'hF; bus.daddr = 32'h0000_0020; bus.din = 32'h1234_5678;
    #2 cpu_rst = 1;
    @(posedge cpu_clk_50M); #1;
    chk("midrst_dm", bus.dm, 32'h0);
    chk("midrst_led", {16'h0, led}, 32'h0);
    chk("midrst_int", {31'h0, timer_int}, 32'h0);
    bus.dce = 0; bus.we = 0;
    @(posedge cpu_clk_50M); #1;
    cpu_rst = 0;
    acc(1, 4'h0, 32'hBFAF_0004, 32'h0);
    chk("rst_timer", bus.dm, 32'h0);
    acc(1, 4'h0, 32'hBFAF_000C, 32'h0);
    chk("rst_compare", bus.dm, 32'hFFFF_FFFF);
    acc(1, 4'h0, 32'h0000_0020, 32'h0);
    chk("ram_kept", bus.dm, 32'hCAFE_F00D);
    acc(1, 4'hF, 32'hBFAF_0040, 32'h7777_7777);
    acc(1, 4'h0, 32'hBFAF_0040, 32'h0);
    chk("unmapped_read", bus.dm, 32'h0);
    acc(1, 4'h0, 32'h4000_0010, 32'h0);
    chk("ram_alias", bus.dm, 32'h1122_AA44);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
